// File: rtl/kronos_bus_arbiter.sv
// rtl/kronos_bus_arbiter.sv - two-master (fetch/data) arbiter for a single-port memory bus
// Owner holds the bus until mem_ack or watchdog expiry; one dead cycle separates transactions.
module kronos_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    output logic        instr_err,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic        data_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t        state;
    logic          last_data;
    logic [WW-1:0] wdog;
    logic          expire;
    logic          finish;
    logic          own_instr;
    logic          own_data;

    // Expiry lands in the TIMEOUT-th cycle of mem_req; a coincident mem_ack wins.
    assign expire    = (wdog == WW'(TIMEOUT - 1)) && !mem_ack;
    assign finish    = (mem_ack || expire) && !rst;
    assign own_instr = (state == INSTR);
    assign own_data  = (state == DATA);

    assign instr_ack    = own_instr && finish;
    assign instr_err    = own_instr && expire && !rst;
    assign instr_data   = (own_instr && mem_ack && !rst) ? mem_rd_data : 32'h0;
    assign data_ack     = own_data && finish;
    assign data_err     = own_data && expire && !rst;
    assign data_rd_data = (own_data && mem_ack && !rst) ? mem_rd_data : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_data   <= 1'b0;
            wdog        <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wr_data <= 32'h0;
            mem_mask    <= 4'h0;
            mem_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    // On conflict the port not served last wins.
                    if (instr_req && (!data_req || last_data)) begin
                        state       <= INSTR;
                        last_data   <= 1'b0;
                        mem_req     <= 1'b1;
                        mem_addr    <= instr_addr;
                        mem_wr_data <= 32'h0;
                        mem_mask    <= 4'hF;
                        mem_wr_en   <= 1'b0;
                    end else if (data_req) begin
                        state       <= DATA;
                        last_data   <= 1'b1;
                        mem_req     <= 1'b1;
                        mem_addr    <= data_addr;
                        mem_wr_data <= data_wr_data;
                        mem_mask    <= data_mask;
                        mem_wr_en   <= data_wr_en;
                    end
                end
                INSTR, DATA: begin
                    if (mem_ack || expire) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        wdog    <= '0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    wdog    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_bus_arbiter.sv
// tb/tb_kronos_bus_arbiter.sv - directed scoreboard bench for kronos_bus_arbiter
module tb_kronos_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr, data_addr, data_wr_data;
    logic        instr_req, data_req, data_wr_en;
    logic [3:0]  data_mask;
    logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        instr_ack, instr_err, data_ack, data_err, mem_wr_en, mem_req, mem_ack;
    logic [3:0]  mem_mask;
    logic [31:0] instr_data3, data_rd_data3, mem_addr3, mem_wr_data3;
    logic        instr_ack3, instr_err3, data_ack3, data_err3, mem_wr_en3, mem_req3;
    logic [3:0]  mem_mask3;

    logic        auto_mem;
    logic        ack_man;
    logic [31:0] rd_man;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign mem_ack     = auto_mem ? mem_req : ack_man;
    assign mem_rd_data = auto_mem ? (mem_addr ^ 32'hA5A5_A5A5) : rd_man;

    kronos_bus_arbiter #(.TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data),
        .instr_ack(instr_ack), .instr_err(instr_err),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_rd_data(data_rd_data),
        .data_ack(data_ack), .data_err(data_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask),
        .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
    );

    kronos_bus_arbiter #(.TIMEOUT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data3),
        .instr_ack(instr_ack3), .instr_err(instr_err3),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_rd_data(data_rd_data3),
        .data_ack(data_ack3), .data_err(data_err3),
        .mem_addr(mem_addr3), .mem_wr_data(mem_wr_data3), .mem_mask(mem_mask3),
        .mem_wr_en(mem_wr_en3), .mem_req(mem_req3), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every ack on the main DUT pops one expected completion.
    always @(negedge clk) begin
        if (instr_ack === 1'b1 || data_ack === 1'b1) begin
            chk("ack_expected", 32'(sb.size() != 0), 32'd1);
            chk("ack_onehot", 32'(instr_ack & data_ack), 32'd0);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", 32'(data_ack), 32'(e.port));
                chk("ack_data", data_ack ? data_rd_data : instr_data, e.data);
                chk("ack_err", 32'(data_ack ? data_err : instr_err), 32'(e.err));
                chk("nonowner_data", data_ack ? instr_data : data_rd_data, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks, win, hi, idx;
        rst = 1'b1; instr_req = 0; data_req = 0; instr_addr = 0; data_addr = 0;
        data_wr_data = 0; data_mask = 0; data_wr_en = 0;
        auto_mem = 0; ack_man = 0; rd_man = 0;
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 32'h0);
        chk("rst_mem_mask", 32'(mem_mask), 32'h0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_acks", 32'({instr_ack, instr_err, data_ack, data_err}), 32'h0);
        chk("rst_rd", instr_data | data_rd_data, 32'h0);
        rst = 1'b0;

        // Single fetch, memory acks one cycle after mem_req
        tick();
        instr_req = 1; instr_addr = 32'h100;
        tick();
        chk("f_mem_req", 32'(mem_req), 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_mask", 32'(mem_mask), 32'hF);
        chk("f_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("f_no_early_ack", 32'(instr_ack), 32'd0);
        tick();
        ack_man = 1; rd_man = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        #1;
        chk("f_instr_ack", 32'(instr_ack), 32'd1);
        chk("f_data_ack", 32'(data_ack), 32'd0);
        tick();
        instr_req = 0; ack_man = 0;
        chk("f_idle_mem_req", 32'(mem_req), 32'd0);

        // Conflict after reset: DATA first, then INSTR after one dead cycle
        do_reset();
        instr_req = 1; instr_addr = 32'h0;
        data_req = 1; data_addr = 32'h200; data_wr_data = 32'h1234_5678;
        data_mask = 4'b0011; data_wr_en = 1;
        tick();
        chk("c_mem_addr", mem_addr, 32'h200);
        chk("c_mem_wr_en", 32'(mem_wr_en), 32'd1);
        chk("c_mem_mask", 32'(mem_mask), 32'h3);
        chk("c_mem_wr_data", mem_wr_data, 32'h1234_5678);
        ack_man = 1; rd_man = 32'h1111_2222;
        sb.push_back('{1'b1, 32'h1111_2222, 1'b0});
        #1;
        chk("c_data_ack", 32'(data_ack), 32'd1);
        tick();
        data_req = 0; ack_man = 0;
        chk("c_dead_cycle", 32'(mem_req), 32'd0);
        tick();
        chk("c_instr_grant", 32'(mem_req), 32'd1);
        chk("c_instr_mask", 32'(mem_mask), 32'hF);
        chk("c_instr_wr_en", 32'(mem_wr_en), 32'd0);
        ack_man = 1; rd_man = 32'h3333_4444;
        sb.push_back('{1'b0, 32'h3333_4444, 1'b0});
        #1;
        chk("c_instr_ack", 32'(instr_ack), 32'd1);
        tick();
        instr_req = 0; ack_man = 0;

        // Alternation with zero-wait memory: D I D I D I
        instr_addr = 32'h300; data_addr = 32'h400; data_wr_en = 0; data_mask = 4'hF;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b1, 32'h400 ^ 32'hA5A5_A5A5, 1'b0});
            sb.push_back('{1'b0, 32'h300 ^ 32'hA5A5_A5A5, 1'b0});
        end
        auto_mem = 1; instr_req = 1; data_req = 1;
        acks = 0; win = 0; hi = 0;
        while (acks < 6 && win < 40) begin
            tick();
            win++;
            if (mem_req) hi++;
            if (instr_ack || data_ack) begin
                acks++;
                if (acks == 6) begin
                    instr_req = 0; data_req = 0;
                end
            end
        end
        chk("alt_acks", 32'(acks), 32'd6);
        chk("alt_windows", 32'(win), 32'd11);
        chk("alt_mem_req_hi", 32'(hi), 32'd6);
        tick();
        auto_mem = 0;
        #1;
        chk("alt_idle", 32'(mem_req), 32'd0);

        // Timeout on a data load (TIMEOUT=4)
        tick();
        data_req = 1; data_addr = 32'h500; data_wr_en = 0;
        sb.push_back('{1'b1, 32'h0, 1'b1});
        tick();
        chk("to_mem_req", 32'(mem_req), 32'd1);
        idx = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            if (data_ack) begin
                idx = i;
                break;
            end
        end
        chk("to_latency", 32'(idx), 32'd4);
        chk("to_err", 32'(data_err), 32'd1);
        data_req = 0;
        tick();
        chk("to_idle", 32'(mem_req), 32'd0);
        tick();
        ack_man = 1; rd_man = 32'hFFFF_0000;
        #1;
        chk("to_late_ack_d", 32'(data_ack), 32'd0);
        chk("to_late_ack_i", 32'(instr_ack), 32'd0);
        tick();
        ack_man = 0;

        // Ack and timeout in the same cycle (TIMEOUT=3 instance)
        do_reset();
        instr_req = 1; instr_addr = 32'h600;
        tick();
        chk("tie_w1_ack", 32'(instr_ack3), 32'd0);
        sb.push_back('{1'b0, 32'h7777_8888, 1'b0});
        tick();
        chk("tie_w2_ack", 32'(instr_ack3), 32'd0);
        tick();
        ack_man = 1; rd_man = 32'h7777_8888;
        #1;
        chk("tie_ack", 32'(instr_ack3), 32'd1);
        chk("tie_err", 32'(instr_err3), 32'd0);
        chk("tie_data", instr_data3, 32'h7777_8888);
        tick();
        instr_req = 0; ack_man = 0;
        tick();

        // Reset while DATA waits, then a conflict goes to DATA first
        data_req = 1; data_addr = 32'h700; data_wr_en = 0;
        tick();
        chk("rm_grant", 32'(mem_req), 32'd1);
        tick();
        rst = 1;
        #1;
        chk("rm_no_ack", 32'(data_ack), 32'd0);
        tick();
        chk("rm_mem_req", 32'(mem_req), 32'd0);
        rst = 0; instr_req = 1; instr_addr = 32'h800;
        tick();
        chk("rm_data_first", mem_addr, 32'h700);
        ack_man = 1; rd_man = 32'h9999_AAAA;
        sb.push_back('{1'b1, 32'h9999_AAAA, 1'b0});
        #1;
        chk("rm_data_ack", 32'(data_ack), 32'd1);
        tick();
        data_req = 0; ack_man = 0;
        tick();
        chk("rm_instr_next", mem_addr, 32'h800);
        ack_man = 1; rd_man = 32'hBBBB_CCCC;
        sb.push_back('{1'b0, 32'hBBBB_CCCC, 1'b0});
        #1;
        chk("rm_instr_ack", 32'(instr_ack), 32'd1);
        tick();
        instr_req = 0; ack_man = 0;
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
